mat_result_serializer: RTL and testbench
========================================

# mat_result_serializer

Reads a completed matrix-product result, captured as one parallel word, and streams its elements out one per transfer over a valid/ready interface. It sits at the output of the matrix-multiply datapath, after the result registers. It is the read side of the parallel result store: the datapath writes the whole matrix at once, and this block drains it element by element to the downstream consumer.

## Interface
- DATA_W, 8, width of one result element in bits
- DIM, 2, matrix dimension; the result is DIM x DIM elements
- IDX_W, max(1, clog2(DIM)), width of the row and column indices
- clk_80  in  1  single clock; all logic is rising-edge
- rst_80  in  1  asynchronous, active-high reset
- load_80  in  1  one-cycle strobe; capture mat_80
- mat_80  in  DIM*DIM*DATA_W  parallel result; element (r,c) occupies bits [(r*DIM+c)*DATA_W +: DATA_W]
- ready_80  in  1  consumer accepts the element
- busy_80  out  1  a matrix is captured and not fully drained
- valid_80  out  1  dout_80 holds a valid element
- dout_80  out  DATA_W  current element
- row_80  out  IDX_W  row index of dout_80
- col_80  out  IDX_W  column index of dout_80
- last_80  out  1  dout_80 is element (DIM-1, DIM-1)
- done_80  out  1  one-cycle pulse after the last transfer
- overrun_80  out  1  sticky; a load_80 arrived while busy_80 was high

## Operation
- FSM states: IDLE and SEND.
- IDLE:
  - load_80=1 captures mat_80 into the shadow register.
  - row and column counters are cleared to 0.
  - The FSM goes to SEND.
- SEND:
  - valid_80=1.
  - dout_80 shows the element at (row, col) from the shadow register.
  - A transfer occurs on a rising edge where valid_80 and ready_80 are both 1.
- Each transfer advances the index in row-major order: col increments; when col = DIM-1, col wraps to 0 and row increments.
- A transfer at (DIM-1, DIM-1) returns the FSM to IDLE and asserts done_80 for the next cycle only.
- busy_80 equals (state == SEND).
- last_80 = valid_80 and (row == DIM-1) and (col == DIM-1).
- load_80 while in SEND, including the cycle of the final transfer:
  - The load is ignored.
  - The shadow register keeps its contents.
  - overrun_80 is set and held until rst_80.
- ready_80 low in SEND:
  - Hold state.
  - dout_80, row_80, col_80 and last_80 stay stable.
  - valid_80 must not drop.
- ready_80 has no effect in IDLE.
- Reset values: state IDLE; all outputs 0; shadow register 0; counters 0.
- Reset asserted mid-stream:
  - The matrix is abandoned immediately.
  - No done_80 pulse is produced.
  - After reset release, the next load_80 is accepted normally.

## Timing
- Load latency: load_80 sampled at edge k gives valid_80=1 and element (0,0) on dout_80 after edge k.
- Throughput: with ready_80 held high, one element per cycle. A full matrix takes DIM*DIM cycles from the first valid_80 cycle.
- After the final transfer at edge m:
  - From edge m, valid_80=0, busy_80=0 and done_80=1.
  - done_80 returns to 0 after edge m+1.
  - load_80 sampled at edge m+1 is accepted.
- Back-to-back matrices therefore always have at least one idle cycle between them.
- All outputs are registered or decoded only from registered state. There is no combinational path from ready_80 or load_80 to any output.

## Structure
- Shared package/include mat_pkg holds:
  - the DATA_W and DIM defaults;
  - the IDX_W derivation;
  - the state encodings (IDLE=1'b0, SEND=1'b1);
  - a function giving the element bit offset for (r,c).
- Sub-module mat_idx_counter:
  - inputs clk_80, rst_80, clr, inc;
  - outputs row, col, at_last;
  - row-major wrap with DIM as a parameter.
- The top level holds the FSM, the shadow register, the element mux, and the done/overrun flags.

## Test plan
- Reset and idle:
  - assert rst_80, then release;
  - all outputs must read 0;
  - toggling ready_80 must not change any output.
- Basic stream:
  - DIM=2, DATA_W=8, mat_80=32'h44332211, load_80 pulsed, ready_80=1;
  - dout_80 must read 11, 22, 33, 44 on consecutive cycles with (row,col) = (0,0), (0,1), (1,0), (1,1);
  - last_80 is high on 44 only;
  - done_80 pulses once, on the cycle after 44.
- Backpressure:
  - same load, ready_80 pattern 1,0,0,1,0,1,1;
  - each element is held stable while ready_80=0;
  - exactly 4 transfers occur, with no duplicates and no skipped elements.
- Overrun:
  - load_80 with mat_80=32'hAABBCCDD during the second element of the stream 32'h44332211;
  - the stream still outputs 11, 22, 33, 44;
  - overrun_80 rises and stays high.
- Final-transfer collision:
  - load_80 in the same cycle as the transfer of 44 is ignored and sets overrun_80;
  - a load on the following cycle starts a new stream.
- Reset mid-stream:
  - assert rst_80 after 2 transfers;
  - all outputs go to 0 immediately and no done_80 pulse appears;
  - a subsequent load of 32'h08070605 streams 05, 06, 07, 08.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared defaults, index-width derivation, FSM encoding and element addressing
// for the matrix result serializer.
package mat_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIM_DEF    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Bit offset of element (r,c) inside the flattened row-major result word.
  function automatic int elem_off(input int r, input int c, input int dim, input int data_w);
    return (r * dim + c) * data_w;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major (row, col) index walker over a DIM x DIM matrix.
module mat_idx_counter
  import mat_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int IDX_W = idx_w(DIM)
) (
  input  logic             clk_80,
  input  logic             rst_80,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             at_last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);

  assign at_last = (row == MAX_IDX) && (col == MAX_IDX);

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mat_result_serializer.sv
// Captures a parallel DIM x DIM result word and drains it one element per
// valid/ready transfer in row-major order.
module mat_result_serializer
  import mat_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM    = DIM_DEF,
  parameter int IDX_W  = idx_w(DIM)
) (
  input  logic                       clk_80,
  input  logic                       rst_80,
  input  logic                       load_80,
  input  logic [DIM*DIM*DATA_W-1:0]  mat_80,
  input  logic                       ready_80,
  output logic                       busy_80,
  output logic                       valid_80,
  output logic [DATA_W-1:0]          dout_80,
  output logic [IDX_W-1:0]           row_80,
  output logic [IDX_W-1:0]           col_80,
  output logic                       last_80,
  output logic                       done_80,
  output logic                       overrun_80
);

  state_t                      state, state_nxt;
  logic [DIM*DIM*DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]           elems [DIM][DIM];
  logic                        at_last;
  logic                        xfer;
  logic                        capture;
  logic                        done_q;
  logic                        overrun_q;

  assign xfer    = (state == SEND) && ready_80;
  assign capture = (state == IDLE) && load_80;

  mat_idx_counter #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk_80  (clk_80),
    .rst_80  (rst_80),
    .clr     (capture),
    .inc     (xfer),
    .row     (row_80),
    .col     (col_80),
    .at_last (at_last)
  );

  for (genvar gr = 0; gr < DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < DIM; gc++) begin : g_col
      assign elems[gr][gc] = shadow[elem_off(gr, gc, DIM, DATA_W) +: DATA_W];
    end
  end

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_80) state_nxt = SEND;
      SEND:    if (xfer && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_80  = 1'b0;
    valid_80 = 1'b0;
    dout_80  = '0;
    last_80  = 1'b0;
    if (state == SEND) begin
      busy_80  = 1'b1;
      valid_80 = 1'b1;
      dout_80  = elems[row_80][col_80];
      last_80  = at_last;
    end
  end

  // Loads arriving while a matrix is still draining are dropped and flagged.
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      shadow    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) shadow <= mat_80;
      done_q <= xfer && at_last;
      if ((state == SEND) && load_80) overrun_q <= 1'b1;
    end
  end

  assign done_80    = done_q;
  assign overrun_80 = overrun_q;

endmodule

// File: tb/tb_mat_result_serializer.sv
// Directed bench for mat_result_serializer (DIM=2, DATA_W=8).
module tb_mat_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] mat;
  logic        ready;
  logic        busy, valid, last, done, overrun;
  logic [7:0]  dout;
  logic [0:0]  row, col;

  int total = 0;
  int bad   = 0;

  mat_result_serializer dut (
    .clk_80     (clk),
    .rst_80     (rst),
    .load_80    (load),
    .mat_80     (mat),
    .ready_80   (ready),
    .busy_80    (busy),
    .valid_80   (valid),
    .dout_80    (dout),
    .row_80     (row),
    .col_80     (col),
    .last_80    (last),
    .done_80    (done),
    .overrun_80 (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected element idx of word m, with its row-major coordinates.
  task automatic chk_elem(input string tag, input int idx, input logic [31:0] m);
    logic [31:0] w;
    w = m >> (idx * 8);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_busy"},  {31'd0, busy},  32'd1);
    chk({tag, "_dout"},  {24'd0, dout},  {24'd0, w[7:0]});
    chk({tag, "_row"},   {31'd0, row},   32'(idx / 2));
    chk({tag, "_col"},   {31'd0, col},   32'(idx % 2));
    chk({tag, "_last"},  {31'd0, last},  32'(idx == 3));
    chk({tag, "_done"},  {31'd0, done},  32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_valid"},   {31'd0, valid},   32'd0);
    chk({tag, "_dout"},    {24'd0, dout},    32'd0);
    chk({tag, "_row"},     {31'd0, row},     32'd0);
    chk({tag, "_col"},     {31'd0, col},     32'd0);
    chk({tag, "_last"},    {31'd0, last},    32'd0);
    chk({tag, "_done"},    {31'd0, done},    32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] pat;
    int         idx;
    int         xfers;

    rst = 1'b1; load = 1'b0; mat = 32'h0; ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    // Reset and idle, ready toggling has no effect
    chk_all_zero("reset");
    ready = 1'b1; tick;
    chk_all_zero("idle_rdy1");
    ready = 1'b0; tick;
    chk_all_zero("idle_rdy0");

    // Basic stream
    mat = 32'h44332211; load = 1'b1; ready = 1'b1;
    tick; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_elem("basic", i, 32'h44332211);
      tick;
    end
    chk("basic_done",   {31'd0, done},  32'd1);
    chk("basic_valid0", {31'd0, valid}, 32'd0);
    chk("basic_busy0",  {31'd0, busy},  32'd0);
    tick;
    chk("basic_done_off", {31'd0, done}, 32'd0);
    chk("basic_ovr",      {31'd0, overrun}, 32'd0);

    // Backpressure: ready pattern 1,0,0,1,0,1,1 (applied first-to-last)
    pat = 7'b1101001;
    mat = 32'h44332211; load = 1'b1;
    tick; load = 1'b0;
    idx = 0; xfers = 0;
    for (int i = 0; i < 7; i++) begin
      chk_elem("bp", idx, 32'h44332211);
      ready = pat[i];
      tick;
      if (pat[i]) begin
        idx++;
        xfers++;
      end
    end
    chk("bp_xfers", 32'(xfers), 32'd4);
    chk("bp_done",  {31'd0, done},  32'd1);
    chk("bp_valid", {31'd0, valid}, 32'd0);
    ready = 1'b1;
    tick;

    // Overrun during the second element
    mat = 32'h44332211; load = 1'b1;
    tick; load = 1'b0;
    chk_elem("ovr", 0, 32'h44332211);
    tick;
    chk_elem("ovr", 1, 32'h44332211);
    chk("ovr_pre", {31'd0, overrun}, 32'd0);
    mat = 32'hAABBCCDD; load = 1'b1;
    tick; load = 1'b0;
    chk_elem("ovr", 2, 32'h44332211);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    tick;
    chk_elem("ovr", 3, 32'h44332211);
    tick;
    chk("ovr_done", {31'd0, done}, 32'd1);
    chk("ovr_hold", {31'd0, overrun}, 32'd1);
    tick;
    chk("ovr_hold2", {31'd0, overrun}, 32'd1);

    // Final-transfer collision, then load on the following cycle
    mat = 32'h44332211; load = 1'b1;
    tick; load = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    chk_elem("coll", 3, 32'h44332211);
    mat = 32'hAABBCCDD; load = 1'b1;
    tick;
    chk("coll_done",  {31'd0, done},  32'd1);
    chk("coll_valid", {31'd0, valid}, 32'd0);
    chk("coll_ovr",   {31'd0, overrun}, 32'd1);
    tick; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_elem("coll2", i, 32'hAABBCCDD);
      tick;
    end
    chk("coll2_done", {31'd0, done}, 32'd1);
    tick;

    // Reset mid-stream after two transfers
    mat = 32'h44332211; load = 1'b1;
    tick; load = 1'b0;
    tick; tick;
    chk_elem("mid", 2, 32'h44332211);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    tick;
    rst = 1'b0;
    tick;
    chk_all_zero("mid_after");
    mat = 32'h08070605; load = 1'b1;
    tick; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_elem("post", i, 32'h08070605);
      tick;
    end
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_ovr",  {31'd0, overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
